vend_ctrl: RTL and testbench
============================

VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter PRICE, 15, item price in cents; SHALL be a nonzero multiple of 5.
REQ-002 Parameter CREDIT_W, 8, credit register width; SHALL hold PRICE+20 without overflow.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 coin_valid  input  1  coin present this cycle.
REQ-006 coin_sel  input  2  coin code: 00=5, 01=10, 10=25, 11=invalid.
REQ-007 cancel  input  1  refund request (see REQ-024).
REQ-008 dispense  output  1  one-cycle item release pulse.
REQ-009 change_pulse  output  1  one 5-cent coin returned per high cycle.
REQ-010 coin_reject  output  1  one-cycle pulse, coin returned to user.
REQ-011 busy  output  1  high in DISPENSE or CHANGE.
REQ-012 credit  output  CREDIT_W  current credit in cents, registered.

Function
REQ-013 FSM states SHALL be IDLE (credit=0), COLLECT (0<credit<PRICE), DISPENSE and CHANGE; dispense, change_pulse and busy SHALL be Moore decodes of the state register.
REQ-014 A coin SHALL be accepted in cycle N when coin_valid=1, coin_sel!=11, cancel inactive and state is IDLE or COLLECT; credit SHALL show credit+value at N+1.
REQ-015 The sum SHALL be computed at CREDIT_W+1 bits; since credit<PRICE before any add, the result cannot exceed PRICE+20.
REQ-016 On acceptance, next state SHALL be DISPENSE if the new credit>=PRICE, else COLLECT.
REQ-017 In DISPENSE (exactly one cycle): dispense=1, credit<=credit-PRICE; next state SHALL be CHANGE if the remainder>0, else IDLE.
REQ-018 In CHANGE: change_pulse=1 each cycle, credit<=credit-5; the state SHALL exit to IDLE in the cycle that credit reaches 0.
REQ-019 coin_valid with coin_sel=11, or in DISPENSE or CHANGE, SHALL be rejected: credit unchanged, coin_reject=1 in the following cycle.
REQ-020 coin_reject SHALL be a registered pulse; back-to-back rejected coins SHALL produce back-to-back pulses.
REQ-021 dispense and change_pulse SHALL never be high in the same cycle.
REQ-022 Total change pulses per transaction SHALL equal (credit-PRICE)/5 after the purchase, or credit/5 after a refund.

Reset
REQ-023 When rst=1 at a rising edge: state=IDLE, credit=0, dispense=0, change_pulse=0, coin_reject=0 and busy=0 from the next cycle; rst SHALL override all inputs, including mid-CHANGE, and any remaining change is forfeited.

Configuration
REQ-024 Macro VEND_CANCEL_EN defined: cancel=1 in COLLECT SHALL move the FSM to CHANGE, refunding all credit via change_pulse with no dispense.
- cancel in IDLE, DISPENSE or CHANGE SHALL be ignored.
- cancel together with coin_valid SHALL take priority and the coin SHALL be rejected per REQ-019.
REQ-025 Macro VEND_CANCEL_EN undefined: the cancel port SHALL remain present but be ignored, and coins SHALL be accepted regardless of cancel.

Verification (PRICE=15)
REQ-026 Coin 5 then coin 10 -> credit 5, then 15 with dispense=1 in the same cycle; then credit 0, IDLE, no change_pulse.
REQ-027 Coin 10 then coin 10 -> credit 20 with dispense=1; then credit 5 with change_pulse=1 for one cycle; then credit 0, IDLE.
REQ-028 Single coin 25 -> dispense=1 with credit 25; then two change_pulse cycles (credit 10, then 5); then 0.
REQ-029 coin_sel=11, and a 10-cent coin during CHANGE -> each gives a coin_reject pulse in the next cycle with credit and FSM progress unchanged.
REQ-030 Credit 10 then cancel -> with VEND_CANCEL_EN: two change_pulse cycles, dispense never high, credit 0; without VEND_CANCEL_EN: credit stays 10.
REQ-031 Coin 25 then rst asserted on the first CHANGE cycle -> next cycle credit 0, IDLE, all outputs 0, no further change_pulse.

Source files
------------

// File: rtl/vend_ctrl.sv
// Coin-operated vending controller: collects 5/10/25 cent coins, dispenses at PRICE, pays change in 5-cent pulses.
// Optional refund-on-cancel feature is enabled by defining VEND_CANCEL_EN.
module vend_ctrl #(
    parameter int PRICE    = 15,
    parameter int CREDIT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_sel,
    input  logic                cancel,
    output logic                dispense,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] COLLECT  = 2'd1;
    localparam logic [1:0] DISPENSE = 2'd2;
    localparam logic [1:0] CHANGE   = 2'd3;

    localparam logic [CREDIT_W:0]   PRICE_EXT = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] NICKEL    = CREDIT_W'(5);

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [CREDIT_W-1:0] credit_nxt;
    logic [CREDIT_W:0]   coin_value;
    logic [CREDIT_W:0]   sum;
    logic                accept;
    logic                reject_nxt;
    logic                cancel_req;
    logic                cancel_block;

`ifdef VEND_CANCEL_EN
    // A cancel blocks any coin offered with it, but only refunds from COLLECT.
    assign cancel_block = cancel;
    assign cancel_req   = cancel && (state == COLLECT);
`else
    assign cancel_block = cancel & 1'b0;
    assign cancel_req   = 1'b0;
`endif

    always_comb begin
        coin_value = '0;
        case (coin_sel)
            2'b00:   coin_value = (CREDIT_W+1)'(5);
            2'b01:   coin_value = (CREDIT_W+1)'(10);
            2'b10:   coin_value = (CREDIT_W+1)'(25);
            default: coin_value = '0;
        endcase
    end

    // Credit is always below PRICE when a coin is added, so the extra sum bit only guards the compare.
    assign sum    = {1'b0, credit} + coin_value;
    assign accept = coin_valid && (coin_sel != 2'b11) && !cancel_block
                    && ((state == IDLE) || (state == COLLECT));
    assign reject_nxt = coin_valid && !accept;

    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        case (state)
            IDLE, COLLECT: begin
                if (cancel_req) begin
                    state_nxt = CHANGE;
                end else if (accept) begin
                    credit_nxt = sum[CREDIT_W-1:0];
                    state_nxt  = (sum >= PRICE_EXT) ? DISPENSE : COLLECT;
                end
            end
            DISPENSE: begin
                credit_nxt = credit - PRICE_C;
                state_nxt  = (credit > PRICE_C) ? CHANGE : IDLE;
            end
            CHANGE: begin
                // The last nickel paid out lands us back in IDLE with zero credit.
                if (credit <= NICKEL) begin
                    credit_nxt = '0;
                    state_nxt  = IDLE;
                end else begin
                    credit_nxt = credit - NICKEL;
                end
            end
            default: begin
                credit_nxt = '0;
                state_nxt  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            credit      <= '0;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_nxt;
            credit      <= credit_nxt;
            coin_reject <= reject_nxt;
        end
    end

    assign dispense     = (state == DISPENSE);
    assign change_pulse = (state == CHANGE);
    assign busy         = (state == DISPENSE) || (state == CHANGE);

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed self-checking bench for vend_ctrl at PRICE=15; expectations follow VEND_CANCEL_EN when defined.
module tb_vend_ctrl;

    logic       clk;
    logic       rst;
    logic       coin_valid;
    logic [1:0] coin_sel;
    logic       cancel;
    logic       dispense;
    logic       change_pulse;
    logic       coin_reject;
    logic       busy;
    logic [7:0] credit;

    int checks;
    int errors;

    vend_ctrl #(.PRICE(15), .CREDIT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin_sel     (coin_sel),
        .cancel       (cancel),
        .dispense     (dispense),
        .change_pulse (change_pulse),
        .coin_reject  (coin_reject),
        .busy         (busy),
        .credit       (credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the edge pass, then return inputs to idle.
    task automatic applyStimulus(input logic valid, input logic [1:0] sel, input logic canc);
        coin_valid = valid;
        coin_sel   = sel;
        cancel     = canc;
        @(posedge clk);
        #1;
        coin_valid = 1'b0;
        coin_sel   = 2'b00;
        cancel     = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] e_credit, input logic e_disp,
                               input logic e_chg, input logic e_rej, input logic e_busy);
        logic [11:0] observed;
        logic [11:0] expected;
        observed = {credit, dispense, change_pulse, coin_reject, busy};
        expected = {e_credit, e_disp, e_chg, e_rej, e_busy};
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: credit/disp/chg/rej/busy got %0d/%b/%b/%b/%b expected %0d/%b/%b/%b/%b",
                   tag, observed[11:4], observed[3], observed[2], observed[1], observed[0],
                   expected[11:4], expected[3], expected[2], expected[1], expected[0]);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        coin_valid = 1'b0;
        coin_sel   = 2'b00;
        cancel     = 1'b0;
        applyStimulus(1'b1, 2'b10, 1'b0);
        checkOutput("reset", 8'd0, 0, 0, 0, 0);
        rst = 1'b0;

        // Exact payment: 5 + 10.
        applyStimulus(1'b1, 2'b00, 1'b0);
        checkOutput("exact_5", 8'd5, 0, 0, 0, 0);
        applyStimulus(1'b1, 2'b01, 1'b0);
        checkOutput("exact_dispense", 8'd15, 1, 0, 0, 1);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("exact_idle", 8'd0, 0, 0, 0, 0);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("exact_no_change", 8'd0, 0, 0, 0, 0);

        // Overpay by 5: 10 + 10.
        applyStimulus(1'b1, 2'b01, 1'b0);
        checkOutput("over5_10", 8'd10, 0, 0, 0, 0);
        applyStimulus(1'b1, 2'b01, 1'b0);
        checkOutput("over5_dispense", 8'd20, 1, 0, 0, 1);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("over5_change", 8'd5, 0, 1, 0, 1);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("over5_idle", 8'd0, 0, 0, 0, 0);

        // Single quarter: dispense then two nickels back.
        applyStimulus(1'b1, 2'b10, 1'b0);
        checkOutput("q_dispense", 8'd25, 1, 0, 0, 1);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("q_change1", 8'd10, 0, 1, 0, 1);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("q_change2", 8'd5, 0, 1, 0, 1);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("q_idle", 8'd0, 0, 0, 0, 0);

        // Invalid coin code and a coin offered while paying change.
        applyStimulus(1'b1, 2'b11, 1'b0);
        checkOutput("bad_code_reject", 8'd0, 0, 0, 1, 0);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("bad_code_clear", 8'd0, 0, 0, 0, 0);
        applyStimulus(1'b1, 2'b10, 1'b0);
        checkOutput("busy_q_dispense", 8'd25, 1, 0, 0, 1);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("busy_q_change1", 8'd10, 0, 1, 0, 1);
        applyStimulus(1'b1, 2'b01, 1'b0);
        checkOutput("busy_coin_reject", 8'd5, 0, 1, 1, 1);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("busy_idle", 8'd0, 0, 0, 0, 0);

        // Back-to-back rejected coins give back-to-back pulses.
        applyStimulus(1'b1, 2'b11, 1'b0);
        checkOutput("b2b_reject1", 8'd0, 0, 0, 1, 0);
        applyStimulus(1'b1, 2'b11, 1'b0);
        checkOutput("b2b_reject2", 8'd0, 0, 0, 1, 0);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("b2b_clear", 8'd0, 0, 0, 0, 0);

        // Cancel with 10 cents of credit.
        applyStimulus(1'b1, 2'b01, 1'b0);
        checkOutput("cancel_credit10", 8'd10, 0, 0, 0, 0);
        applyStimulus(1'b0, 2'b00, 1'b1);
`ifdef VEND_CANCEL_EN
        checkOutput("cancel_refund1", 8'd10, 0, 1, 0, 1);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("cancel_refund2", 8'd5, 0, 1, 0, 1);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("cancel_idle", 8'd0, 0, 0, 0, 0);
        applyStimulus(1'b1, 2'b00, 1'b0);
        checkOutput("cancel_coin_5", 8'd5, 0, 0, 0, 0);
        applyStimulus(1'b1, 2'b00, 1'b1);
        checkOutput("cancel_coin_reject", 8'd5, 0, 1, 1, 1);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("cancel_coin_idle", 8'd0, 0, 0, 0, 0);
`else
        checkOutput("cancel_ignored", 8'd10, 0, 0, 0, 0);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("cancel_hold", 8'd10, 0, 0, 0, 0);
        applyStimulus(1'b1, 2'b00, 1'b1);
        checkOutput("cancel_coin_dispense", 8'd15, 1, 0, 0, 1);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("cancel_coin_idle", 8'd0, 0, 0, 0, 0);
        applyStimulus(1'b1, 2'b00, 1'b1);
        checkOutput("cancel_coin_accept", 8'd5, 0, 0, 0, 0);
        applyStimulus(1'b1, 2'b01, 1'b0);
        checkOutput("cancel_coin_dispense2", 8'd15, 1, 0, 0, 1);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("cancel_coin_idle2", 8'd0, 0, 0, 0, 0);
`endif

        // Reset on the first change cycle forfeits the remaining change.
        applyStimulus(1'b1, 2'b10, 1'b0);
        checkOutput("rst_q_dispense", 8'd25, 1, 0, 0, 1);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("rst_q_change1", 8'd10, 0, 1, 0, 1);
        rst = 1'b1;
        applyStimulus(1'b1, 2'b11, 1'b0);
        checkOutput("rst_mid_change", 8'd0, 0, 0, 0, 0);
        rst = 1'b0;
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("rst_no_more_change", 8'd0, 0, 0, 0, 0);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("rst_stays_idle", 8'd0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
